note_prompter: RTL and testbench

- Game-side counterpart to the player switch/confirm input path.
- Generates pseudo-random 4-bit target finger patterns at a fixed tempo and presents each one to the display for a timed window.
- Judges the player's confirmed 4-bit value against the current target and tracks score, lives and game-over.
- Sits between the game top level (display/LED driver) and the player input block.

---
 rtl/note_prompter_if.sv | 25 ++
 rtl/note_prompter.sv | 151 +++++++++++++++
 tb/tb_note_prompter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/note_prompter_if.sv
// Bus between note_prompter and the game side: player strobes in, target/score/status out.
interface note_prompter_if #(
  parameter int unsigned SCORE_W = 8
);
  logic               start;
  logic [3:0]         val;
  logic               val_valid;
  logic [3:0]         note;
  logic               note_valid;
  logic               hit;
  logic               miss;
  logic [SCORE_W-1:0] score;
  logic [1:0]         lives;
  logic               game_over;

  modport master (
    output start, val, val_valid,
    input  note, note_valid, hit, miss, score, lives, game_over
  );

  modport slave (
    input  start, val, val_valid,
    output note, note_valid, hit, miss, score, lives, game_over
  );
endinterface

// File: rtl/note_prompter.sv
// Rhythm-game note generator/judge: LFSR targets shown per beat window, score/lives tracking.
// Optional tempo speed-up on every 8th hit when NOTE_PROMPTER_SPEEDUP_EN is defined.
module note_prompter #(
  parameter int unsigned BEAT_CYCLES = 25000000,
  parameter int unsigned NOTE_BEATS  = 2,
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int unsigned SCORE_W     = 8
) (
  input logic            clk,
  input logic            rst_n,
  note_prompter_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(BEAT_CYCLES + 1);
  localparam int unsigned BT_W  = $clog2(NOTE_BEATS + 1);
  localparam logic [CNT_W-1:0] BEAT_FULL = CNT_W'(BEAT_CYCLES);
  localparam logic [BT_W-1:0]  LAST_BEAT = BT_W'(NOTE_BEATS - 1);

  typedef enum logic [1:0] {IDLE, SHOW, GAP, OVER} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   limit;
  logic [BT_W-1:0]    beats;
  logic [15:0]        lfsr;
  logic [15:0]        lfsr_next;
  logic               beat_tick;
  logic               correct;
  logic               win;
  logic               lose;
  logic               restart;
  logic               enter_show;

  logic [3:0]         note_q;
  logic               note_valid_q;
  logic               hit_q;
  logic               miss_q;
  logic [SCORE_W-1:0] score_q;
  logic [1:0]         lives_q;
  logic               game_over_q;

  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign beat_tick = (cnt == limit - CNT_W'(1));
  assign correct   = (bus.val == note_q);

`ifdef NOTE_PROMPTER_SPEEDUP_EN
  localparam logic [CNT_W-1:0] FLOOR = CNT_W'(BEAT_CYCLES >> 1);

  logic [CNT_W-1:0] beat_limit;
  logic [CNT_W-1:0] shrunk;
  logic [2:0]       hit_cnt;

  assign shrunk = beat_limit - (beat_limit >> 3);
  assign limit  = beat_limit;

  // Tempo tightens by 1/8 on every eighth hit, never below half the nominal beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_limit <= BEAT_FULL;
      hit_cnt    <= 3'd0;
    end else if (restart) begin
      beat_limit <= BEAT_FULL;
    end else if (win) begin
      hit_cnt <= hit_cnt + 3'd1;
      if (hit_cnt == 3'd7) beat_limit <= (shrunk < FLOOR) ? FLOOR : shrunk;
    end
  end
`else
  assign limit = BEAT_FULL;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next state plus judgement strobes; the input beats a coincident final beat_tick.
  always_comb begin
    state_d = state;
    win     = 1'b0;
    lose    = 1'b0;
    restart = 1'b0;
    case (state)
      IDLE: if (bus.start) state_d = SHOW;
      SHOW: begin
        if (bus.val_valid) begin
          win  = correct;
          lose = !correct;
        end else if (beat_tick && beats == LAST_BEAT) begin
          lose = 1'b1;
        end
        if (win)       state_d = GAP;
        else if (lose) state_d = (lives_q == 2'd1) ? OVER : GAP;
      end
      GAP:  if (beat_tick) state_d = SHOW;
      OVER: if (bus.start) begin
        restart = 1'b1;
        state_d = SHOW;
      end
      default: state_d = IDLE;
    endcase
  end

  assign enter_show = (state_d == SHOW) && (state != SHOW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr         <= SEED;
      cnt          <= '0;
      beats        <= '0;
      note_q       <= 4'h0;
      note_valid_q <= 1'b0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
      score_q      <= '0;
      lives_q      <= 2'd3;
      game_over_q  <= 1'b0;
    end else begin
      hit_q        <= win;
      miss_q       <= lose;
      note_valid_q <= (state_d == SHOW);
      game_over_q  <= (state_d == OVER);

      if (enter_show) begin
        note_q <= (lfsr[3:0] == 4'h0) ? 4'h1 : lfsr[3:0];
        lfsr   <= lfsr_next;
      end else if (state_d != SHOW) begin
        note_q <= 4'h0;
      end

      if (state_d != state || beat_tick) cnt <= '0;
      else                               cnt <= cnt + CNT_W'(1);

      if (state_d != state)                  beats <= '0;
      else if (state == SHOW && beat_tick)   beats <= beats + BT_W'(1);

      if (restart)                 score_q <= '0;
      else if (win && score_q != '1) score_q <= score_q + SCORE_W'(1);

      if (restart)   lives_q <= 2'd3;
      else if (lose) lives_q <= lives_q - 2'd1;
    end
  end

  assign bus.note       = note_q;
  assign bus.note_valid = note_valid_q;
  assign bus.hit        = hit_q;
  assign bus.miss       = miss_q;
  assign bus.score      = score_q;
  assign bus.lives      = lives_q;
  assign bus.game_over  = game_over_q;
endmodule

// File: tb/tb_note_prompter.sv
// Bench for note_prompter: directed table, randomized notes against a game-level model,
// async reset mid-note and score saturation on a narrow-score twin.
module tb_note_prompter;
  localparam int unsigned BEAT     = 4;
  localparam int unsigned NB       = 2;
  localparam int unsigned SHOW_CYC = BEAT * NB;
  localparam logic [15:0] SEED     = 16'hACE1;

  logic clk;
  logic rst_n;

  note_prompter_if #(.SCORE_W(8)) bus ();
  note_prompter_if #(.SCORE_W(2)) bus2 ();

  note_prompter #(.BEAT_CYCLES(BEAT), .NOTE_BEATS(NB), .SEED(SEED), .SCORE_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  note_prompter #(.BEAT_CYCLES(BEAT), .NOTE_BEATS(NB), .SEED(SEED), .SCORE_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  assign bus2.start     = bus.start;
  assign bus2.val       = bus.val;
  assign bus2.val_valid = bus.val_valid;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  // Game-level reference model
  logic [15:0] m_lfsr;
  int          m_score;
  int          m_lives;
  bit          m_over;

  typedef struct {
    int kind;       // 0 correct, 1 wrong, 2 timeout, 3 start from OVER
    int k;          // SHOW cycle index at which the answer is given
    bit poke;       // stray val_valid/start inside the GAP
    int exp_score;
    int exp_lives;
    bit exp_over;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], ^(l & 16'hB400)};
  endfunction

  function automatic logic [3:0] note_of(input logic [15:0] l);
    return (l[3:0] == 4'h0) ? 4'h1 : l[3:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_lfsr  = SEED;
    m_score = 0;
    m_lives = 3;
    m_over  = 1'b0;
  endtask

  // One note from its first SHOW cycle through the following GAP (or into OVER).
  task automatic run_note(input int kind, input int k, input bit poke);
    logic [3:0] exp_note;
    bit         early;
    bit         stray;
    int         gap;
    int         wait_cyc;
    exp_note = note_of(m_lfsr);
    m_lfsr   = lfsr_step(m_lfsr);
    check("note_valid_show", 32'(bus.note_valid), 32'd1);
    check("note_value", 32'(bus.note), 32'(exp_note));
    wait_cyc = (kind == 2) ? int'(SHOW_CYC) - 1 : k;
    early = 1'b0;
    for (int i = 0; i < wait_cyc; i++) begin
      tick();
      if (bus.hit || bus.miss || !bus.note_valid) early = 1'b1;
    end
    check("no_early_pulse", 32'(early), 32'd0);
    if (kind != 2) begin
      bus.val       = (kind == 0) ? exp_note : (exp_note ^ 4'hF);
      bus.val_valid = 1'b1;
    end
    tick();
    bus.val_valid = 1'b0;
    if (kind == 0) begin
      m_score = (m_score < 255) ? m_score + 1 : 255;
    end else begin
      m_lives = m_lives - 1;
      if (m_lives == 0) m_over = 1'b1;
    end
    check("hit", 32'(bus.hit), 32'(kind == 0));
    check("miss", 32'(bus.miss), 32'(kind != 0));
    check("score", 32'(bus.score), 32'(m_score));
    check("lives", 32'(bus.lives), 32'(m_lives));
    check("game_over", 32'(bus.game_over), 32'(m_over));
    check("note_cleared", 32'(bus.note), 32'd0);
    if (!m_over) begin
      gap   = 0;
      stray = 1'b0;
      while (!bus.note_valid && gap < 20) begin
        gap++;
        if (poke && gap == 2) begin
          bus.val       = 4'($urandom);
          bus.val_valid = 1'b1;
        end
        if (poke && gap == 3) bus.start = 1'b1;
        tick();
        bus.val_valid = 1'b0;
        bus.start     = 1'b0;
        if (bus.hit || bus.miss) stray = 1'b1;
      end
      check("gap_len", 32'(gap), 32'(BEAT));
      check("gap_no_pulse", 32'(stray), 32'd0);
    end
  endtask

  task automatic restart_game();
    bus.val       = 4'($urandom);
    bus.val_valid = 1'b1;
    tick();
    bus.val_valid = 1'b0;
    check("over_ignores_val", 32'(bus.hit | bus.miss), 32'd0);
    check("over_held", 32'(bus.game_over), 32'd1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    m_score = 0;
    m_lives = 3;
    m_over  = 1'b0;
    check("restart_score", 32'(bus.score), 32'd0);
    check("restart_lives", 32'(bus.lives), 32'd3);
    check("restart_over", 32'(bus.game_over), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit bad_idle;
    n_cmp = 0;
    n_bad = 0;
    vecs[0]  = '{0, 0, 1'b0, 1, 3, 1'b0};
    vecs[1]  = '{2, 0, 1'b1, 1, 2, 1'b0};
    vecs[2]  = '{0, 7, 1'b0, 2, 2, 1'b0};
    vecs[3]  = '{1, 2, 1'b0, 2, 1, 1'b0};
    vecs[4]  = '{0, 3, 1'b1, 3, 1, 1'b0};
    vecs[5]  = '{1, 5, 1'b0, 3, 0, 1'b1};
    vecs[6]  = '{3, 0, 1'b0, 0, 3, 1'b0};
    vecs[7]  = '{1, 0, 1'b0, 0, 2, 1'b0};
    vecs[8]  = '{1, 1, 1'b0, 0, 1, 1'b0};
    vecs[9]  = '{1, 6, 1'b0, 0, 0, 1'b1};
    vecs[10] = '{3, 0, 1'b0, 0, 3, 1'b0};
    vecs[11] = '{0, 1, 1'b0, 1, 3, 1'b0};

    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.val       = 4'h0;
    bus.val_valid = 1'b0;
    model_reset();
    #22;
    check("rst_note_valid", 32'(bus.note_valid), 32'd0);
    check("rst_lives", 32'(bus.lives), 32'd3);
    rst_n = 1'b1;
    tick();

    bad_idle = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.val       = 4'($urandom);
      bus.val_valid = 1'($urandom);
      tick();
      if (bus.note_valid || bus.note != 4'h0 || bus.hit || bus.miss || bus.game_over ||
          bus.score != 8'd0 || bus.lives != 2'd3) bad_idle = 1'b1;
    end
    bus.val_valid = 1'b0;
    check("idle_quiet", 32'(bad_idle), 32'd0);

    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].kind == 3) begin
        restart_game();
        check("tbl_nv_after_start", 32'(bus.note_valid), 32'd1);
      end else begin
        run_note(vecs[i].kind, vecs[i].k, vecs[i].poke);
      end
      check("tbl_score", 32'(bus.score), 32'(vecs[i].exp_score));
      check("tbl_lives", 32'(bus.lives), 32'(vecs[i].exp_lives));
      check("tbl_over", 32'(bus.game_over), 32'(vecs[i].exp_over));
    end

    for (int i = 0; i < 50; i++) begin
      if (m_over) restart_game();
      run_note(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0,
               int'($urandom_range(0, SHOW_CYC - 1)), 1'($urandom));
    end

    // Asynchronous reset in the middle of a SHOW window
    if (m_over) restart_game();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_note_valid", 32'(bus.note_valid), 32'd0);
    check("arst_note", 32'(bus.note), 32'd0);
    check("arst_score", 32'(bus.score), 32'd0);
    check("arst_lives", 32'(bus.lives), 32'd3);
    check("arst_over", 32'(bus.game_over), 32'd0);
    #10;
    rst_n = 1'b1;
    model_reset();
    tick();
    check("arst_idle_nv", 32'(bus.note_valid), 32'd0);

    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) run_note(0, int'($urandom_range(0, SHOW_CYC - 1)), 1'b0);
    check("narrow_score_sat", 32'(bus2.score), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
